// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: 8-digit multiplexed seven-segment driver with frame-aligned word commit
// Optional LEADING_ZERO_BLANK_EN suppresses leading zero digits (digit 0 always shown)
module seg7_scan_driver #(
  parameter int SCAN_DIV = 12500,
  parameter int BLANK_CYCLES = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_digits,
  input  logic [7:0]  in_dp,
  input  logic [7:0]  in_en,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [7:0]  an,
  output logic        frame_done
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLAST = CW'(BLANK_CYCLES - 1);
  typedef enum logic {BLANK, SHOW} state_t;
  state_t st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic full, commit, lit, dp_n, fd_n;
  logic [31:0] pd, ad, ad_n;
  logic [7:0] pdp, pen, adp, aen, adp_n, aen_n, an_n;
  logic [6:0] seg_n;
  logic [3:0] nib;
  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= BLANK;
      cnt <= '0;
      idx <= '0;
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      idx <= idx_n;
    end
  end
  always_comb begin
    cnt_n = (cnt == LAST) ? '0 : cnt + 1'b1;
    idx_n = (cnt == LAST) ? idx + 3'd1 : idx;
    st_n = (cnt == LAST) ? BLANK : (cnt == BLAST) ? SHOW : st;
  end
  // outputs are built from the next state so they line up with the state register
  always_comb begin
    commit = frame_done & full;
    ad_n = commit ? pd : ad;
    adp_n = commit ? pdp : adp;
    aen_n = commit ? pen : aen;
    nib = ad_n[{idx_n, 2'b00} +: 4];
    fd_n = (idx_n == 3'd7) && (cnt_n == LAST);
  end
`ifdef LEADING_ZERO_BLANK_EN
  logic [31:0] mw;
  logic [7:0] nz;
  always_comb begin
    mw = '0;
    nz = '0;
    for (int k = 0; k < 8; k++) mw[4*k +: 4] = ad_n[4*k +: 4] & {4{aen_n[k]}};
    for (int k = 0; k < 8; k++) nz[k] = |(mw >> (4*k));
  end
  assign lit = (st_n == SHOW) && aen_n[idx_n] && ((idx_n == 3'd0) || nz[idx_n]);
`else
  assign lit = (st_n == SHOW) && aen_n[idx_n];
`endif
  always_comb begin
    an_n = lit ? ~(8'd1 << idx_n) : 8'hFF;
    seg_n = lit ? hex7(nib) : 7'h7F;
    dp_n = lit ? ~adp_n[idx_n] : 1'b1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
      pd <= '0;
      pdp <= '0;
      pen <= '0;
      ad <= '0;
      adp <= '0;
      aen <= '0;
      an <= 8'hFF;
      seg <= 7'h7F;
      dp <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      if (in_valid && !full) begin
        full <= 1'b1;
        pd <= in_digits;
        pdp <= in_dp;
        pen <= in_en;
      end else if (commit) full <= 1'b0;
      ad <= ad_n;
      adp <= adp_n;
      aen <= aen_n;
      an <= an_n;
      seg <= seg_n;
      dp <= dp_n;
      frame_done <= fd_n;
    end
  end
  assign in_ready = ~full;
endmodule
